// File: rtl/game_pkg.sv
// Shared types and helpers for the symmetric counter game.
// State encoding, 7-segment codes and BCD arithmetic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        WIN
    } stateT;

    localparam int LEVEL_W = 2;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] bcdToSeg(
        input logic [3:0] d
    );
        logic [6:0] s;
        unique case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] bcdInc(
        input logic [15:0] v
    );
        logic [15:0] r;
        logic carry;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic isPalindrome(
        input logic [15:0] v
    );
        return (v[15:12] == v[3:0]) &&
               (v[11:8] == v[7:4]);
    endfunction

endpackage

// File: rtl/game_btn.sv
// Button conditioner: 2-FF sync, debounce, press pulse.
// Accepted level moves only after a full stable window.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnIn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST =
        CW'(DEBOUNCE_CYCLES - 1);

    logic syncA;
    logic syncB;
    logic stable;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= btnIn;
            syncB <= syncA;
        end
    end

    // Debounce window; a rising accept emits one pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (syncB == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= syncB;
                press  <= syncB;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game.sv
// Symmetric counter reaction game top level.
// Counter, state machine, speed level and display scan.
module game
    import game_pkg::*;
#(
    parameter int TICK_DIV        = 10_000_000,
    parameter int REFRESH_DIV     = 100_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  logic       Clk100Mhz,
    input  logic       rst_n,
    input  logic       btnS,
    input  logic       btnU,
    input  logic       btnD,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [RW-1:0] REF_LAST =
        RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST =
        BW'(BLINK_DIV - 1);

    logic pressS;
    logic pressU;
    logic pressD;

    stateT state;
    stateT stateNext;
    logic [15:0] count;
    logic [15:0] countNext;

    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] levelNext;
    logic levelChg;

    logic [TW-1:0] tickCnt;
    logic [TW-1:0] tickLast;
    logic [31:0] period;
    logic tick;

    logic [RW-1:0] refCnt;
    logic [1:0] scanIdx;
    logic [BW-1:0] blinkCnt;
    logic blinkOn;
    logic [3:0] digit;
    logic dpLit;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBtnS (
        .clk  (Clk100Mhz),
        .rst_n(rst_n),
        .btnIn(btnS),
        .press(pressS)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBtnU (
        .clk  (Clk100Mhz),
        .rst_n(rst_n),
        .btnIn(btnU),
        .press(pressU)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBtnD (
        .clk  (Clk100Mhz),
        .rst_n(rst_n),
        .btnIn(btnD),
        .press(pressD)
    );

    // Saturating speed level; opposing presses cancel.
    always_comb begin
        levelNext = level;
        if (pressU && !pressD && level != LEVEL_MAX) begin
            levelNext = level + 1'b1;
        end else if (pressD && !pressU && level != '0) begin
            levelNext = level - 1'b1;
        end
        levelChg = (levelNext != level);
    end

    // Level register.
    always_ff @(posedge Clk100Mhz) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= levelNext;
        end
    end

    // Tick period shrinks by powers of two with level.
    always_comb begin
        period   = 32'(TICK_DIV) >> level;
        tickLast = (period > 32'd1) ?
            TW'(period - 32'd1) : '0;
        tick     = (state == RUN) && (tickCnt == tickLast);
    end

    // Prescaler idles at zero outside RUN, so entry starts fresh.
    always_ff @(posedge Clk100Mhz) begin
        if (!rst_n) begin
            tickCnt <= '0;
        end else if (state != RUN || levelChg || tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    // Next state and count; a stop press freezes pre-tick value.
    always_comb begin
        stateNext = state;
        countNext = count;
        unique case (state)
            IDLE: begin
                countNext = '0;
                if (pressS) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (pressS) begin
                    stateNext = isPalindrome(count) ? WIN : HOLD;
                end else if (tick) begin
                    countNext = bcdInc(count);
                end
            end
            HOLD: begin
                if (pressS) begin
                    stateNext = RUN;
                end
            end
            WIN: begin
                if (pressS) begin
                    stateNext = IDLE;
                    countNext = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    // State and count registers.
    always_ff @(posedge Clk100Mhz) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Blink phase restarts "on" whenever WIN is entered.
    always_ff @(posedge Clk100Mhz) begin
        if (!rst_n || state != WIN) begin
            blinkCnt <= '0;
            blinkOn  <= 1'b1;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blinkOn  <= ~blinkOn;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    // Digit scan, one digit per refresh slot.
    always_ff @(posedge Clk100Mhz) begin
        if (!rst_n) begin
            refCnt  <= '0;
            scanIdx <= '0;
        end else if (refCnt == REF_LAST) begin
            refCnt  <= '0;
            scanIdx <= scanIdx + 1'b1;
        end else begin
            refCnt <= refCnt + 1'b1;
        end
    end

    // Segment and anode drive for the scanned digit.
    always_comb begin
        digit = count[scanIdx*4 +: 4];
        dpLit = (state == WIN) || (scanIdx == level);
        seg   = {~dpLit, bcdToSeg(digit)};
        if (state == WIN && !blinkOn) begin
            an = 4'b1111;
        end else begin
            an = ~(4'b0001 << scanIdx);
        end
    end

endmodule

// File: tb/tb_game.sv
// Directed self-checking bench for the game top level.
// Small dividers keep every scenario short.
module tb_game;
    import game_pkg::*;

    localparam int TD = 16;
    localparam int RD = 4;
    localparam int DB = 4;
    localparam int BD = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btnS = 1'b0;
    logic btnU = 1'b0;
    logic btnD = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [7:0] seg;
    } scanVecT;

    scanVecT vec[6];

    game #(
        .TICK_DIV(TD),
        .REFRESH_DIV(RD),
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIV(BD)
    ) dut (
        .Clk100Mhz(clk),
        .rst_n(rst_n),
        .btnS(btnS),
        .btnU(btnU),
        .btnD(btnD),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [3:0] decode(
        input logic [6:0] s
    );
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    task automatic readDisp(
        output logic [15:0] val,
        output logic [3:0] dpMask
    );
        int idx;
        val = 16'hFFFF;
        dpMask = 4'b0000;
        for (int i = 0; i < 4 * RD; i++) begin
            idx = -1;
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx >= 0) begin
                val[idx*4 +: 4] = decode(seg[6:0]);
                dpMask[idx] = ~seg[7];
            end
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pressBtn(input int which);
        case (which)
            0: btnS = 1'b1;
            1: btnU = 1'b1;
            default: btnD = 1'b1;
        endcase
        repeat (DB + 8) @(negedge clk);
        btnS = 1'b0;
        btnU = 1'b0;
        btnD = 1'b0;
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic waitCount(
        input logic [15:0] target,
        input int budget
    );
        int n = 0;
        while (dut.count !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach count", 32'(dut.count), 32'(target));
    endtask

    task automatic waitState(
        input stateT target,
        input int budget
    );
        int n = 0;
        while (dut.state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach state", 32'(dut.state), 32'(target));
    endtask

    task automatic waitChange(input int budget);
        logic [15:0] old;
        int n = 0;
        old = dut.count;
        while (dut.count === old && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            chk("count change timeout", 32'(n), 32'(0));
        end
    endtask

    task automatic measurePeriod(output int p);
        logic [15:0] old;
        waitChange(200);
        old = dut.count;
        p = 0;
        while (dut.count === old && p < 200) begin
            @(negedge clk);
            p++;
        end
    endtask

    initial begin
        logic [15:0] val;
        logic [3:0] dpm;
        int cyc;
        int p;

        vec[0] = '{0,  4'b1110, 8'h40};
        vec[1] = '{3,  4'b1110, 8'h40};
        vec[2] = '{4,  4'b1101, 8'hC0};
        vec[3] = '{8,  4'b1011, 8'hC0};
        vec[4] = '{12, 4'b0111, 8'hC0};
        vec[5] = '{16, 4'b1110, 8'h40};

        @(negedge clk);
        doReset();
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            while (cyc < vec[i].k) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("scan an %0d", i),
                32'(an), 32'(vec[i].an));
            chk($sformatf("scan seg %0d", i),
                32'(seg), 32'(vec[i].seg));
        end

        pressBtn(0);
        chk("start run", 32'(dut.state), 32'(RUN));
        waitCount(16'h0012, 1000);
        btnS = 1'b1;
        waitState(HOLD, 20);
        repeat (DB + 8) @(negedge clk);
        btnS = 1'b0;
        repeat (DB + 8) @(negedge clk);
        readDisp(val, dpm);
        chk("hold value", 32'(val), 32'h0012);
        chk("hold dp", 32'(dpm), 32'b0001);
        repeat (100 * TD) @(negedge clk);
        readDisp(val, dpm);
        chk("hold stays", 32'(val), 32'h0012);

        doReset();
        pressBtn(0);
        waitCount(16'h0110, 3000);
        btnS = 1'b1;
        waitState(WIN, 20);
        readDisp(val, dpm);
        chk("win value", 32'(val), 32'h0110);
        chk("win dp", 32'(dpm), 32'b1111);
        repeat (47) @(negedge clk);
        chk("blink on k63", 32'(an == 4'b1111), 32'(0));
        @(negedge clk);
        chk("blink off k64", 32'(an), 32'b1111);
        repeat (63) @(negedge clk);
        chk("blink off k127", 32'(an), 32'b1111);
        @(negedge clk);
        chk("blink on k128", 32'(an == 4'b1111), 32'(0));
        btnS = 1'b0;
        repeat (DB + 8) @(negedge clk);
        pressBtn(0);
        chk("win to idle", 32'(dut.state), 32'(IDLE));
        readDisp(val, dpm);
        chk("idle value", 32'(val), 32'h0000);

        for (int i = 0; i < 5; i++) pressBtn(1);
        chk("level max", 32'(dut.level), 32'(3));
        readDisp(val, dpm);
        chk("dp level3", 32'(dpm), 32'b1000);
        pressBtn(0);
        measurePeriod(p);
        chk("period lvl3", 32'(p), 32'(2));
        waitCount(16'h9999, 25000);
        waitChange(20);
        chk("wrap 0000", 32'(dut.count), 32'h0000);
        waitChange(20);
        chk("wrap 0001", 32'(dut.count), 32'h0001);
        for (int i = 0; i < 5; i++) pressBtn(2);
        chk("level min", 32'(dut.level), 32'(0));
        measurePeriod(p);
        chk("period lvl0", 32'(p), 32'(16));
        pressBtn(1);
        chk("level one", 32'(dut.level), 32'(1));
        btnU = 1'b1;
        btnD = 1'b1;
        repeat (DB + 8) @(negedge clk);
        btnU = 1'b0;
        btnD = 1'b0;
        repeat (DB + 8) @(negedge clk);
        chk("both level", 32'(dut.level), 32'(1));
        measurePeriod(p);
        chk("period lvl1", 32'(p), 32'(8));

        btnS = 1'b1;
        repeat (2) @(negedge clk);
        btnS = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch ignored", 32'(dut.state), 32'(RUN));

        doReset();
        pressBtn(0);
        waitCount(16'h0457, 10000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst state", 32'(dut.state), 32'(IDLE));
        chk("rst count", 32'(dut.count), 32'h0000);
        chk("rst an", 32'(an), 32'b1110);
        chk("rst seg", 32'(seg), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
